// File: rtl/wb_writeback_queue_pkg.sv
// Shared writeback control types: opcodes, regfile mux selects, load extension, queue entry.
package wb_writeback_queue_pkg;

   // Widest datapath an entry can carry; narrower XLEN uses the low bits.
   localparam int unsigned WbDataMax = 64;

   localparam logic [6:0] OpLui   = 7'b0110111;
   localparam logic [6:0] OpAuipc = 7'b0010111;
   localparam logic [6:0] OpJal   = 7'b1101111;
   localparam logic [6:0] OpJalr  = 7'b1100111;
   localparam logic [6:0] OpLoad  = 7'b0000011;
   localparam logic [6:0] OpImm   = 7'b0010011;
   localparam logic [6:0] OpReg   = 7'b0110011;

   typedef enum logic [2:0] {
      RfmAluOut,
      RfmBrEn,
      RfmUImm,
      RfmPcPlus4,
      RfmLoad
   } rfmux_sel_e;

   typedef enum logic [2:0] {
      ExtWord,
      ExtByteS,
      ExtByteU,
      ExtHalfS,
      ExtHalfU
   } load_ext_e;

   typedef struct packed {
      logic [4:0]           rd;
      logic [WbDataMax-1:0] data;
   } wb_entry_t;

   // Load funct3 to extension mode; lw and undefined encodings pass the full word.
   function automatic load_ext_e load_ext_from_funct3(input logic [2:0] funct3);
      load_ext_e ext;
      case (funct3)
         3'b000:  ext = ExtByteS;
         3'b001:  ext = ExtHalfS;
         3'b100:  ext = ExtByteU;
         3'b101:  ext = ExtHalfU;
         default: ext = ExtWord;
      endcase
      return ext;
   endfunction

endpackage

// File: rtl/wb_lane_format.sv
// Per-lane writeback source select and load data alignment/extension.
module wb_lane_format
   import wb_writeback_queue_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [6:0]      opcode_i,
   input  logic [2:0]      funct3_i,
   input  logic [6:0]      funct7_i,
   input  logic [XLEN-1:0] alu_out_i,
   input  logic [XLEN-1:0] u_imm_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] mem_rdata_i,
   input  logic            br_en_i,
   input  logic [1:0]      addr_lo_i,
   output logic [XLEN-1:0] data_o
);

   rfmux_sel_e      sel;
   load_ext_e       ext;
   logic [XLEN-1:0] shifted;
   logic [XLEN-1:0] load_data;

   // Decode which writeback candidate this instruction retires.
   always_comb begin
      sel = RfmAluOut;
      case (opcode_i)
         OpImm:         sel = (funct3_i == 3'b010 || funct3_i == 3'b011) ? RfmBrEn : RfmAluOut;
         OpLui:         sel = RfmUImm;
         OpAuipc:       sel = RfmAluOut;
         OpJal, OpJalr: sel = RfmPcPlus4;
         // slt/sltu compare result, but not the M-extension mulhsu/mulhu encodings
         OpReg:         sel = (funct3_i[2:1] == 2'b01 && funct7_i != 7'b0000001) ?
                              RfmBrEn : RfmAluOut;
         OpLoad:        sel = RfmLoad;
         default:       sel = RfmAluOut;
      endcase
   end

   assign ext     = load_ext_from_funct3(funct3_i);
   assign shifted = mem_rdata_i >> {addr_lo_i, 3'b000};

   // Extend the addressed byte/half of the loaded word.
   always_comb begin
      load_data = shifted;
      case (ext)
         ExtByteS: load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
         ExtByteU: load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
         ExtHalfS: load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         ExtHalfU: load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
         default:  load_data = shifted;
      endcase
   end

   // Final regfile mux.
   always_comb begin
      data_o = alu_out_i;
      case (sel)
         RfmBrEn:    data_o = {{(XLEN-1){1'b0}}, br_en_i};
         RfmUImm:    data_o = u_imm_i;
         RfmPcPlus4: data_o = pc_i + XLEN'(4);
         RfmLoad:    data_o = load_data;
         default:    data_o = alu_out_i;
      endcase
   end

endmodule

// File: rtl/wb_writeback_queue.sv
// Multi-lane MEM/WB retire queue draining one regfile write per cycle, with forwarding.
module wb_writeback_queue
   import wb_writeback_queue_pkg::*;
#(
   parameter int unsigned NUM_LANES = 2,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned XLEN      = 32
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_LANES-1:0]            in_valid,
   output logic                            in_ready,
   input  logic [NUM_LANES-1:0][6:0]       in_opcode,
   input  logic [NUM_LANES-1:0][2:0]       in_funct3,
   input  logic [NUM_LANES-1:0][6:0]       in_funct7,
   input  logic [NUM_LANES-1:0][4:0]       in_rd,
   input  logic [NUM_LANES-1:0][XLEN-1:0]  in_alu_out,
   input  logic [NUM_LANES-1:0][XLEN-1:0]  in_u_imm,
   input  logic [NUM_LANES-1:0][XLEN-1:0]  in_pc,
   input  logic [NUM_LANES-1:0][XLEN-1:0]  in_mem_rdata,
   input  logic [NUM_LANES-1:0]            in_br_en,
   input  logic [NUM_LANES-1:0][1:0]       in_addr_lo,
   output logic                            rf_we,
   output logic [4:0]                      rf_rd,
   output logic [XLEN-1:0]                 rf_data,
   input  logic                            rf_ready,
   input  logic [1:0][4:0]                 fwd_rs,
   output logic [1:0]                      fwd_hit,
   output logic [1:0][XLEN-1:0]            fwd_data,
   output logic [$clog2(DEPTH):0]          count
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = $clog2(DEPTH) + 1;

   logic [PtrW-1:0]               head_q, head_d, tail_q, tail_d;
   logic [CntW-1:0]               count_q, count_d;
   wb_entry_t                     mem_q [DEPTH];
   wb_entry_t                     mem_d [DEPTH];
   wb_entry_t                     push_entry;
   wb_entry_t                     head_entry;
   wb_entry_t                     fwd_entry;
   logic [NUM_LANES-1:0][XLEN-1:0] lane_data;
   logic [NUM_LANES-1:0]          lane_push;
   logic                          pop;
   int unsigned                   push_cnt;

   function automatic logic [PtrW-1:0] wrap_ptr(input logic [PtrW-1:0] base,
                                                input int unsigned off);
      logic [31:0] sum;
      sum = 32'(base) + off;
      return PtrW'(sum % DEPTH);
   endfunction

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      wb_lane_format #(
         .XLEN(XLEN)
      ) u_lane_format (
         .opcode_i   (in_opcode[l]),
         .funct3_i   (in_funct3[l]),
         .funct7_i   (in_funct7[l]),
         .alu_out_i  (in_alu_out[l]),
         .u_imm_i    (in_u_imm[l]),
         .pc_i       (in_pc[l]),
         .mem_rdata_i(in_mem_rdata[l]),
         .br_en_i    (in_br_en[l]),
         .addr_lo_i  (in_addr_lo[l]),
         .data_o     (lane_data[l])
      );
   end

   // Space check uses registered count only, so a pop this cycle never widens acceptance.
   assign in_ready = (32'(DEPTH) - 32'(count_q)) >= 32'(NUM_LANES);

   // Compact accepted lanes onto consecutive tail slots; update pointers and occupancy.
   always_comb begin
      mem_d      = mem_q;
      push_cnt   = 0;
      push_entry = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         lane_push[i] = in_valid[i] & in_ready & (in_rd[i] != 5'd0);
         if (lane_push[i]) begin
            push_entry                 = '0;
            push_entry.rd              = in_rd[i];
            push_entry.data[XLEN-1:0]  = lane_data[i];
            mem_d[wrap_ptr(tail_q, push_cnt)] = push_entry;
            push_cnt++;
         end
      end
      pop     = (count_q != '0) & rf_ready;
      tail_d  = wrap_ptr(tail_q, push_cnt);
      head_d  = pop ? wrap_ptr(head_q, 1) : head_q;
      count_d = CntW'(32'(count_q) + push_cnt - (pop ? 32'd1 : 32'd0));
   end

   // Control state; reset empties the queue immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage; contents are don't-care while count says the slot is empty.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Head presents its write; outputs are zeroed while empty so nothing stale leaks out.
   always_comb begin
      head_entry = mem_q[head_q];
      rf_we      = (count_q != '0);
      rf_rd      = rf_we ? head_entry.rd : 5'd0;
      rf_data    = rf_we ? head_entry.data[XLEN-1:0] : '0;
   end

   assign count = count_q;

   // Forwarding scans oldest to youngest so the last match seen is the youngest.
   always_comb begin
      fwd_hit   = '0;
      fwd_data  = '0;
      fwd_entry = '0;
      for (int p = 0; p < 2; p++) begin
         for (int k = 0; k < DEPTH; k++) begin
            if (32'(k) < 32'(count_q)) begin
               fwd_entry = mem_q[wrap_ptr(head_q, k)];
               if (fwd_entry.rd == fwd_rs[p]) begin
                  fwd_hit[p]  = 1'b1;
                  fwd_data[p] = fwd_entry.data[XLEN-1:0];
               end
            end
         end
         for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_push[i] && in_rd[i] == fwd_rs[p]) begin
               fwd_hit[p]  = 1'b1;
               fwd_data[p] = lane_data[i];
            end
         end
         if (fwd_rs[p] == 5'd0) begin
            fwd_hit[p]  = 1'b0;
            fwd_data[p] = '0;
         end
      end
   end

endmodule

// File: tb/tb_wb_writeback_queue.sv
// Directed bench for wb_writeback_queue (NUM_LANES=2, DEPTH=4, XLEN=32).
module tb_wb_writeback_queue;
   import wb_writeback_queue_pkg::*;

   localparam int unsigned NL = 2;
   localparam int unsigned D  = 4;
   localparam int unsigned XL = 32;

   logic                      clk = 1'b0;
   logic                      rst = 1'b1;
   logic [NL-1:0]             in_valid;
   logic                      in_ready;
   logic [NL-1:0][6:0]        in_opcode;
   logic [NL-1:0][2:0]        in_funct3;
   logic [NL-1:0][6:0]        in_funct7;
   logic [NL-1:0][4:0]        in_rd;
   logic [NL-1:0][XL-1:0]     in_alu_out;
   logic [NL-1:0][XL-1:0]     in_u_imm;
   logic [NL-1:0][XL-1:0]     in_pc;
   logic [NL-1:0][XL-1:0]     in_mem_rdata;
   logic [NL-1:0]             in_br_en;
   logic [NL-1:0][1:0]        in_addr_lo;
   logic                      rf_we;
   logic [4:0]                rf_rd;
   logic [XL-1:0]             rf_data;
   logic                      rf_ready;
   logic [1:0][4:0]           fwd_rs;
   logic [1:0]                fwd_hit;
   logic [1:0][XL-1:0]        fwd_data;
   logic [$clog2(D):0]        count;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   logic [4:0]  m_rd[$];
   logic [31:0] m_data[$];
   logic [4:0]  v_rd[NL];
   logic [31:0] v_data[NL];
   bit          exp_ready;
   bit          exp_pop;

   always #5 clk = ~clk;

   wb_writeback_queue #(
      .NUM_LANES(NL),
      .DEPTH    (D),
      .XLEN     (XL)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_opcode   (in_opcode),
      .in_funct3   (in_funct3),
      .in_funct7   (in_funct7),
      .in_rd       (in_rd),
      .in_alu_out  (in_alu_out),
      .in_u_imm    (in_u_imm),
      .in_pc       (in_pc),
      .in_mem_rdata(in_mem_rdata),
      .in_br_en    (in_br_en),
      .in_addr_lo  (in_addr_lo),
      .rf_we       (rf_we),
      .rf_rd       (rf_rd),
      .rf_data     (rf_data),
      .rf_ready    (rf_ready),
      .fwd_rs      (fwd_rs),
      .fwd_hit     (fwd_hit),
      .fwd_data    (fwd_data),
      .count       (count)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_lanes();
      in_valid     = '0;
      in_opcode    = '0;
      in_funct3    = '0;
      in_funct7    = '0;
      in_rd        = '0;
      in_alu_out   = '0;
      in_u_imm     = '0;
      in_pc        = '0;
      in_mem_rdata = '0;
      in_br_en     = '0;
      in_addr_lo   = '0;
   endtask

   task automatic drive_lane(input int l, input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input logic [4:0] rd,
                             input logic [31:0] alu, input logic [31:0] uimm,
                             input logic [31:0] pc, input logic [31:0] mrd,
                             input logic br, input logic [1:0] lo);
      in_valid[l]     = 1'b1;
      in_opcode[l]    = op;
      in_funct3[l]    = f3;
      in_funct7[l]    = f7;
      in_rd[l]        = rd;
      in_alu_out[l]   = alu;
      in_u_imm[l]     = uimm;
      in_pc[l]        = pc;
      in_mem_rdata[l] = mrd;
      in_br_en[l]     = br;
      in_addr_lo[l]   = lo;
   endtask

   // addi-style lane: writes alu_out
   task automatic push_alu(input int l, input logic [4:0] rd, input logic [31:0] data);
      drive_lane(l, OpImm, 3'b000, 7'd0, rd, data, 32'd0, 32'd0, 32'd0, 1'b0, 2'd0);
   endtask

   initial begin
      clear_lanes();
      rf_ready = 1'b0;
      fwd_rs   = '0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      check("rst_count", count, 0);
      check("rst_we", rf_we, 0);
      check("rst_rd", rf_rd, 0);
      check("rst_data", rf_data, 0);
      check("rst_fwd_hit", fwd_hit, 0);
      check("rst_ready", in_ready, 1);
      rst = 1'b0;

      // Load extension, one-cycle latency from an empty queue
      rf_ready = 1'b1;
      drive_lane(0, OpLoad, 3'b000, 7'd0, 5'd5, 32'd0, 32'd0, 32'd0, 32'h80FF7F00, 1'b0, 2'd2);
      tick();
      clear_lanes();
      check("lb_count", count, 1);
      check("lb_we", rf_we, 1);
      check("lb_rd", rf_rd, 5);
      check("lb_data", rf_data, 32'hFFFFFFFF);
      tick();
      check("lb_popped", count, 0);
      check("lb_idle_we", rf_we, 0);
      drive_lane(0, OpLoad, 3'b100, 7'd0, 5'd6, 32'd0, 32'd0, 32'd0, 32'h80FF7F00, 1'b0, 2'd1);
      drive_lane(1, OpLoad, 3'b001, 7'd0, 5'd7, 32'd0, 32'd0, 32'd0, 32'h80FF7F00, 1'b0, 2'd2);
      tick();
      clear_lanes();
      check("lbu_count", count, 2);
      check("lbu_rd", rf_rd, 6);
      check("lbu_data", rf_data, 32'h0000007F);
      tick();
      check("lh_rd", rf_rd, 7);
      check("lh_data", rf_data, 32'hFFFF80FF);
      tick();
      check("lh_drained", count, 0);

      // jal pc+4, slt compare result
      drive_lane(0, OpJal, 3'b000, 7'd0, 5'd1, 32'hDEAD, 32'd0, 32'h100, 32'd0, 1'b0, 2'd0);
      drive_lane(1, OpReg, 3'b010, 7'd0, 5'd9, 32'h55, 32'd0, 32'd0, 32'd0, 1'b1, 2'd0);
      tick();
      clear_lanes();
      check("jal_rd", rf_rd, 1);
      check("jal_data", rf_data, 32'h104);
      tick();
      check("slt_rd", rf_rd, 9);
      check("slt_data", rf_data, 1);
      tick();
      check("jal_drained", count, 0);
      drive_lane(0, OpJal, 3'b000, 7'd0, 5'd0, 32'hDEAD, 32'd0, 32'h100, 32'd0, 1'b0, 2'd0);
      tick();
      clear_lanes();
      check("rd0_count", count, 0);
      check("rd0_we", rf_we, 0);

      // lui u_imm, mulhsu keeps alu_out
      drive_lane(0, OpLui, 3'b000, 7'd0, 5'd8, 32'h99, 32'h12345000, 32'd0, 32'd0, 1'b0, 2'd0);
      drive_lane(1, OpReg, 3'b010, 7'b0000001, 5'd10, 32'hABCD, 32'd0, 32'd0, 32'd0, 1'b1, 2'd0);
      tick();
      clear_lanes();
      check("lui_data", rf_data, 32'h12345000);
      tick();
      check("mulhsu_data", rf_data, 32'hABCD);
      tick();

      // Forwarding: youngest wins, rs=0 never hits
      rf_ready = 1'b0;
      push_alu(0, 5'd3, 32'h11);
      push_alu(1, 5'd3, 32'h22);
      fwd_rs[0] = 5'd3;
      fwd_rs[1] = 5'd0;
      #1;
      check("fwd_lane_hit", fwd_hit[0], 1);
      check("fwd_lane_data", fwd_data[0], 32'h22);
      check("fwd_rs0_hit", fwd_hit[1], 0);
      tick();
      clear_lanes();
      check("fwd_q_hit", fwd_hit[0], 1);
      check("fwd_q_data", fwd_data[0], 32'h22);
      push_alu(0, 5'd3, 32'h33);
      #1;
      check("fwd_incoming_data", fwd_data[0], 32'h33);
      tick();
      clear_lanes();
      check("fwd_count", count, 3);
      rf_ready = 1'b1;
      check("fwd_pop0", rf_data, 32'h11);
      tick();
      check("fwd_pop1", rf_data, 32'h22);
      tick();
      check("fwd_pop2", rf_data, 32'h33);
      tick();
      check("fwd_empty_hit", fwd_hit[0], 0);
      fwd_rs = '0;

      // Fill to DEPTH with regfile stalled, then drain in order
      rf_ready = 1'b0;
      push_alu(0, 5'd10, 32'hA0);
      push_alu(1, 5'd11, 32'hA1);
      tick();
      check("fill_count2", count, 2);
      check("fill_ready2", in_ready, 1);
      push_alu(0, 5'd12, 32'hA2);
      push_alu(1, 5'd13, 32'hA3);
      tick();
      check("fill_count4", count, 4);
      check("fill_ready4", in_ready, 0);
      push_alu(0, 5'd14, 32'hA4);
      push_alu(1, 5'd15, 32'hA5);
      tick();
      clear_lanes();
      check("full_reject", count, 4);
      check("full_head_rd", rf_rd, 10);
      check("full_head_data", rf_data, 32'hA0);
      rf_ready = 1'b1;
      tick();
      check("drain_c3", count, 3);
      check("drain_ready3", in_ready, 0);
      check("drain_rd11", rf_rd, 11);
      tick();
      check("drain_ready2", in_ready, 1);
      check("drain_rd12", rf_rd, 12);
      tick();
      check("drain_rd13", rf_rd, 13);
      tick();
      check("drain_c0", count, 0);

      // Simultaneous push and pop
      rf_ready = 1'b0;
      push_alu(0, 5'd20, 32'hB0);
      push_alu(1, 5'd21, 32'hB1);
      tick();
      rf_ready = 1'b1;
      push_alu(0, 5'd22, 32'hB2);
      push_alu(1, 5'd23, 32'hB3);
      tick();
      clear_lanes();
      check("pushpop_count", count, 3);
      check("pushpop_rd", rf_rd, 21);
      repeat (3) tick();
      check("pushpop_drained", count, 0);

      // Pointer wrap with a scoreboard over 3*DEPTH cycles of mixed traffic
      for (int k = 0; k < 3 * D; k++) begin
         exp_ready = (m_rd.size() <= D - NL);
         check("wrap_count", count, m_rd.size());
         check("wrap_ready", in_ready, exp_ready);
         check("wrap_we", rf_we, m_rd.size() != 0);
         if (m_rd.size() != 0) begin
            check("wrap_rd", rf_rd, m_rd[0]);
            check("wrap_data", rf_data, m_data[0]);
         end
         rf_ready = (k % 3 != 0);
         for (int i = 0; i < NL; i++) begin
            v_rd[i]   = 5'((k * NL + i) % 31 + 1);
            v_data[i] = 32'h1000 * k + i;
            push_alu(i, v_rd[i], v_data[i]);
         end
         tick();
         exp_pop = (m_rd.size() != 0) && rf_ready;
         if (exp_pop) begin
            void'(m_rd.pop_front());
            void'(m_data.pop_front());
         end
         if (exp_ready) begin
            for (int i = 0; i < NL; i++) begin
               m_rd.push_back(v_rd[i]);
               m_data.push_back(v_data[i]);
            end
         end
      end
      clear_lanes();
      rf_ready = 1'b1;
      for (int c = 0; c < 16 && m_rd.size() != 0; c++) begin
         check("wrap_drain_rd", rf_rd, m_rd[0]);
         check("wrap_drain_data", rf_data, m_data[0]);
         tick();
         void'(m_rd.pop_front());
         void'(m_data.pop_front());
      end
      check("wrap_drain_done", count, 0);

      // Asynchronous reset mid-drain
      rf_ready = 1'b0;
      push_alu(0, 5'd30, 32'hC0);
      push_alu(1, 5'd31, 32'hC1);
      tick();
      clear_lanes();
      push_alu(0, 5'd29, 32'hC2);
      tick();
      clear_lanes();
      check("prerst_count", count, 3);
      rf_ready = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      check("rst_mid_count", count, 0);
      check("rst_mid_we", rf_we, 0);
      tick();
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("post_rst_we", rf_we, 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
